motor_drive: RTL and testbench
==============================

Name: motor_drive

Overview:
- Back end of the motor command interface: consumes the 4-bit direction word and 2-bit enable from the line-following controller; drives the dual H-bridge (L298-style) pins.
- Per channel: PWM speed, soft-start ramp, and dead-time whenever direction reverses, so the controller's instantaneous direction flips never short or slam the bridge.
- Sits between the controller and the board pins; one instance per rover.

Parameters:
- PWM_BITS, 8, width of the PWM counter and the duty values.
- DEADTIME, 16, clock cycles both bridge inputs are held low with enable low on a direction change.
- RAMP_STEP, 8, duty increment per ramp tick.
- RAMP_DIV, 4, clock cycles per ramp tick.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- motorIn  in  4  direction command. Bits [3:2] drive channel A; bits [1:0] drive channel B. 10 = forward, 01 = reverse, 00 or 11 = brake.
- motorEn  in  2  channel enables. Bit 1 is channel A; bit 0 is channel B.
- duty  in  PWM_BITS  target duty, shared by both channels.
- in_a  out  2  bridge inputs IN1/IN2 for channel A.
- in_b  out  2  bridge inputs IN3/IN4 for channel B.
- en_a  out  1  PWM enable for channel A.
- en_b  out  1  PWM enable for channel B.
- settling  out  2  bit 1 = A, bit 0 = B; high while that channel is in DEAD.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0.
  - both channels in OFF; cur_duty = 0; PWM counter = 0.
- Input synchronization: motorIn and motorEn pass through a 2-flop synchronizer. duty is treated as quasi-static and is sampled directly.
- Latency: all outputs are registered. A change on motorIn/motorEn reaches the pins 3 cycles later.
- PWM counter: free-running, 0 to 2^PWM_BITS-1, wraps to 0, shared by both channels.
  - pwm_x = (counter < cur_duty_x).
  - duty 0 = always low; maximum high time is (2^PWM_BITS-1)/2^PWM_BITS.
- Per-channel FSM: OFF, RUN, BRAKE, DEAD. In the rules below, dir = the synchronized 2-bit code, en = the synchronized enable bit.
  - Any state, en=0: go to OFF next cycle (highest priority). Aborts DEAD and the ramp.
  - OFF: pins 00, en_x = 0, cur_duty = 0.
    - en=1 and dir 10/01: latch dir, go to RUN.
    - en=1 and dir 00/11: go to BRAKE.
  - RUN: pins = latched dir, en_x = pwm_x.
    - Ramp: every RAMP_DIV cycles, cur_duty = min(cur_duty + RAMP_STEP, duty). The add is computed at PWM_BITS+1 width, so it never wraps.
    - If duty drops below cur_duty, cur_duty = duty on the next cycle.
    - dir changes to the opposite valid code: go to DEAD.
    - dir becomes 00/11: go to BRAKE.
  - BRAKE: pins 11, en_x = 1 (hard brake), cur_duty = 0.
    - dir changes to 10/01: go to DEAD.
  - DEAD: pins 00, en_x = 0, settling_x = 1, cur_duty = 0, counter counts DEADTIME cycles.
    - If dir changes during DEAD, the counter restarts and the new dir is captured.
    - On expiry with a valid dir: latch it and go to RUN (ramp starts from 0).
    - On expiry with dir 00/11: go to BRAKE.
  - Entry to RUN from OFF needs no DEAD, because the bridge was already coasting.
- Channels are fully independent apart from the shared PWM counter and shared duty.
- Invariant: the pins must never go from 10 to 01, or from 01 to 10, in adjacent cycles.

Test Plan:
- Reset, then motorEn=11, motorIn=1010, duty=200 -> in_a = in_b = 10 at cycle 3. cur_duty climbs 8, 16, … every 4 cycles and saturates at 200 after 100 cycles. en_a is high for counter < 200.
- From RUN, motorIn 1010 -> 0110 -> on channel A:
  - in_a = 00, en_a = 0, settling = 10 for exactly 16 cycles;
  - then in_a = 01 with the ramp restarting from 0;
  - channel B is undisturbed.
- Mid-DEAD, flip motorIn again (A back to 10) -> dead counter restarts; A resumes 10 exactly 16 cycles after the last flip. Assert no adjacent-cycle 10<->01 transition on any pin pair, for the whole run.
- motorIn = 0000 with motorEn = 11 -> both channels show pins 11, en = 1. Then motorIn = 1001 -> each channel passes through 16-cycle DEAD, then A = 10, B = 01.
- In RUN at cur_duty = 200, drop duty to 50 -> cur_duty = 50 next cycle. Then drop motorEn[1] = 0 -> channel A goes to OFF (pins 00, en_a = 0) at cycle 3; B keeps running.
- Assert rst_n during DEAD, and during the ramp -> all outputs are 0 immediately (asynchronously). After release with the enables held, channels re-enter RUN from OFF with no DEAD period.

Source files
------------

// File: rtl/motor_drive.sv
// Dual H-bridge back end: synchronizes the controller's direction/enable words and drives
// two L298-style channels with shared-counter PWM, soft-start ramp and reversal dead-time.
module motor_drive #(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned DEADTIME  = 16,
  parameter int unsigned RAMP_STEP = 8,
  parameter int unsigned RAMP_DIV  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          motorIn,
  input  logic [1:0]          motorEn,
  input  logic [PWM_BITS-1:0] duty,
  output logic [1:0]          in_a,
  output logic [1:0]          in_b,
  output logic                en_a,
  output logic                en_b,
  output logic [1:0]          settling
);

  localparam int unsigned DeadW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam int unsigned DivW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DeadW-1:0]  DeadLast = DeadW'(DEADTIME - 1);
  localparam logic [DivW-1:0]   DivLast  = DivW'(RAMP_DIV - 1);
  localparam logic [PWM_BITS:0] Step     = (PWM_BITS + 1)'(RAMP_STEP);

  typedef enum logic [1:0] {StOff, StRun, StBrake, StDead} state_e;

  // Index 1 is channel A, index 0 is channel B (matches motorEn bit order).
  logic [3:0]          in_meta_q, in_sync_q;
  logic [1:0]          en_meta_q, en_sync_q;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  state_e              state_q [2];
  state_e              state_d [2];
  logic [1:0]          dir_q   [2];
  logic [1:0]          dir_d   [2];
  logic [PWM_BITS-1:0] cur_q   [2];
  logic [PWM_BITS-1:0] cur_d   [2];
  logic [DeadW-1:0]    dead_q  [2];
  logic [DeadW-1:0]    dead_d  [2];
  logic [DivW-1:0]     div_q   [2];
  logic [DivW-1:0]     div_d   [2];
  logic [1:0]          pins_q  [2];
  logic [1:0]          pins_d  [2];
  logic [1:0]          dir_s   [2];
  logic [PWM_BITS:0]   sum     [2];
  logic [1:0]          en_q, en_d, settle_q, settle_d;

  assign dir_s[1] = in_sync_q[3:2];
  assign dir_s[0] = in_sync_q[1:0];
  // One bit wider than the duty so the ramp add can never wrap.
  assign sum[1]   = {1'b0, cur_q[1]} + Step;
  assign sum[0]   = {1'b0, cur_q[0]} + Step;
  assign cnt_d    = cnt_q + PWM_BITS'(1);

  // Two-flop synchronizer for the controller's direction and enable words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_meta_q <= '0;
      in_sync_q <= '0;
      en_meta_q <= '0;
      en_sync_q <= '0;
    end else begin
      in_meta_q <= motorIn;
      in_sync_q <= in_meta_q;
      en_meta_q <= motorEn;
      en_sync_q <= en_meta_q;
    end
  end

  // Per-channel next state, ramp, dead-time count and next (registered) pin values
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_d[c]  = state_q[c];
      dir_d[c]    = dir_q[c];
      dead_d[c]   = '0;
      cur_d[c]    = '0;
      div_d[c]    = '0;
      pins_d[c]   = 2'b00;
      en_d[c]     = 1'b0;
      settle_d[c] = 1'b0;

      if (!en_sync_q[c]) begin
        state_d[c] = StOff;
      end else begin
        case (state_q[c])
          StOff: begin
            if (^dir_s[c]) begin
              state_d[c] = StRun;
              dir_d[c]   = dir_s[c];
            end else begin
              state_d[c] = StBrake;
            end
          end
          StRun: begin
            if (!(^dir_s[c])) begin
              state_d[c] = StBrake;
            end else if (dir_s[c] != dir_q[c]) begin
              state_d[c] = StDead;
              dir_d[c]   = dir_s[c];
            end
          end
          StBrake: begin
            if (^dir_s[c]) begin
              state_d[c] = StDead;
              dir_d[c]   = dir_s[c];
            end
          end
          StDead: begin
            // A new direction while settling restarts the wait (dead_d stays 0).
            if (dir_s[c] != dir_q[c]) begin
              dir_d[c] = dir_s[c];
            end else if (dead_q[c] == DeadLast) begin
              state_d[c] = (^dir_s[c]) ? StRun : StBrake;
            end
          end
          default: state_d[c] = StOff;
        endcase
      end

      if (state_d[c] == StDead && state_q[c] == StDead && dir_s[c] == dir_q[c]) begin
        dead_d[c] = dead_q[c] + DeadW'(1);
      end

      // Ramp only while staying in RUN; any entry into RUN starts from zero duty.
      if (state_d[c] == StRun && state_q[c] == StRun) begin
        div_d[c] = (div_q[c] == DivLast) ? '0 : div_q[c] + DivW'(1);
        cur_d[c] = cur_q[c];
        if (duty < cur_q[c]) begin
          cur_d[c] = duty;
        end else if (div_q[c] == DivLast) begin
          cur_d[c] = (sum[c] > {1'b0, duty}) ? duty : sum[c][PWM_BITS-1:0];
        end
      end

      case (state_d[c])
        StRun: begin
          pins_d[c] = dir_d[c];
          en_d[c]   = (cnt_d < cur_d[c]);
        end
        StBrake: begin
          pins_d[c] = 2'b11;
          en_d[c]   = 1'b1;
        end
        StDead:  settle_d[c] = 1'b1;
        default: ;
      endcase
    end
  end

  // Channel state, PWM counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      en_q     <= '0;
      settle_q <= '0;
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= StOff;
        dir_q[c]   <= 2'b00;
        cur_q[c]   <= '0;
        dead_q[c]  <= '0;
        div_q[c]   <= '0;
        pins_q[c]  <= 2'b00;
      end
    end else begin
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      settle_q <= settle_d;
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        dir_q[c]   <= dir_d[c];
        cur_q[c]   <= cur_d[c];
        dead_q[c]  <= dead_d[c];
        div_q[c]   <= div_d[c];
        pins_q[c]  <= pins_d[c];
      end
    end
  end

  assign in_a     = pins_q[1];
  assign in_b     = pins_q[0];
  assign en_a     = en_q[1];
  assign en_b     = en_q[0];
  assign settling = settle_q;

endmodule

// File: tb/tb_motor_drive.sv
// Self-checking bench for motor_drive: directed scenarios plus random commands, all compared
// against a cycle-level behavioural model of the channel rules.
module tb_motor_drive;
  localparam int unsigned PWM_BITS  = 8;
  localparam int unsigned DEADTIME  = 16;
  localparam int unsigned RAMP_STEP = 8;
  localparam int unsigned RAMP_DIV  = 4;
  localparam int PERIOD = 1 << PWM_BITS;
  localparam int M_OFF = 0, M_RUN = 1, M_BRK = 2, M_DEAD = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [3:0]          motorIn = '0;
  logic [1:0]          motorEn = '0;
  logic [PWM_BITS-1:0] duty = '0;
  logic [1:0]          in_a, in_b, settling;
  logic                en_a, en_b;
  logic [7:0]          dut_vec;
  int                  vectors = 0;
  int                  miscompares = 0;

  motor_drive #(
    .PWM_BITS (PWM_BITS),
    .DEADTIME (DEADTIME),
    .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .motorIn (motorIn),
    .motorEn (motorEn),
    .duty    (duty),
    .in_a    (in_a),
    .in_b    (in_b),
    .en_a    (en_a),
    .en_b    (en_b),
    .settling(settling)
  );

  always #5 clk = ~clk;
  assign dut_vec = {in_a, in_b, en_a, en_b, settling};

  // Reference model: index 1 = channel A, 0 = channel B. Directions held as ints 0..3.
  int         m_mode [2];
  int         m_dir  [2];
  int         m_left [2];
  int         m_cur  [2];
  int         m_age  [2];
  int         m_cnt;
  logic [5:0] m_h1, m_h2;

  function automatic bit valid_dir(input int d);
    return (d == 1) || (d == 2);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = M_OFF; m_dir[c] = 0; m_left[c] = 0; m_cur[c] = 0; m_age[c] = 0;
    end
    m_cnt = 0; m_h1 = '0; m_h2 = '0;
  endtask

  task automatic model_ch(input int c, input int d, input bit e);
    if (!e) begin
      m_mode[c] = M_OFF;
      m_cur[c]  = 0;
      return;
    end
    case (m_mode[c])
      M_OFF: begin
        if (valid_dir(d)) begin
          m_mode[c] = M_RUN; m_dir[c] = d; m_cur[c] = 0; m_age[c] = 0;
        end else m_mode[c] = M_BRK;
      end
      M_RUN: begin
        m_age[c]++;
        if (!valid_dir(d)) begin
          m_mode[c] = M_BRK; m_cur[c] = 0;
        end else if (d != m_dir[c]) begin
          m_mode[c] = M_DEAD; m_dir[c] = d; m_left[c] = DEADTIME; m_cur[c] = 0;
        end else if (int'(duty) < m_cur[c]) begin
          m_cur[c] = int'(duty);
        end else if (m_age[c] % RAMP_DIV == 0) begin
          m_cur[c] = (m_cur[c] + RAMP_STEP > int'(duty)) ? int'(duty) : m_cur[c] + RAMP_STEP;
        end
      end
      M_BRK: begin
        if (valid_dir(d)) begin
          m_mode[c] = M_DEAD; m_dir[c] = d; m_left[c] = DEADTIME;
        end
      end
      default: begin
        if (d != m_dir[c]) begin
          m_dir[c] = d; m_left[c] = DEADTIME;
        end else if (m_left[c] == 1) begin
          if (valid_dir(d)) begin
            m_mode[c] = M_RUN; m_cur[c] = 0; m_age[c] = 0;
          end else m_mode[c] = M_BRK;
        end else m_left[c]--;
      end
    endcase
  endtask

  // Inputs reach the channel logic two edges after they are sampled.
  task automatic model_step();
    model_ch(1, int'(m_h2[5:4]), m_h2[1]);
    model_ch(0, int'(m_h2[3:2]), m_h2[0]);
    m_cnt = (m_cnt + 1) % PERIOD;
    m_h2 = m_h1;
    m_h1 = {motorIn, motorEn};
  endtask

  function automatic logic [3:0] exp_ch(input int c);
    case (m_mode[c])
      M_RUN:   return {2'(m_dir[c]), (m_cnt < m_cur[c]), 1'b0};
      M_BRK:   return 4'b1110;
      M_DEAD:  return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [3:0] a, b;
    a = exp_ch(1);
    b = exp_ch(0);
    return {a[3:2], b[3:2], a[1], b[1], a[0], b[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  // Pin pairs must never flip directly between forward and reverse.
  initial begin
    logic [1:0] prev_a, prev_b;
    prev_a = 2'b00;
    prev_b = 2'b00;
    forever begin
      @(negedge clk);
      vectors++;
      if ((prev_a == 2'b10 && in_a == 2'b01) || (prev_a == 2'b01 && in_a == 2'b10) ||
          (prev_b == 2'b10 && in_b == 2'b01) || (prev_b == 2'b01 && in_b == 2'b10)) begin
        miscompares++;
        $display("FAIL invariant: a %b->%b b %b->%b, required no 10<->01 step",
                 prev_a, in_a, prev_b, in_b);
      end
      prev_a = in_a;
      prev_b = in_b;
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    motorIn = '0; motorEn = '0; duty = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (dut_vec !== 8'h00) begin
      miscompares++; $display("FAIL reset_outputs: got %b want 00000000", dut_vec);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL reset_idle t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_ramp();
    int cnt_a;
    motorEn = 2'b11; motorIn = 4'b1010; duty = 8'd200;
    for (int i = 1; i <= 120; i++) begin
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL ramp t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (i == 2 || i == 3) begin
        vectors++;
        if ({in_a, in_b} !== ((i == 3) ? 4'b1010 : 4'b0000)) begin
          miscompares++; $display("FAIL ramp_latency t=%0d: pins %b", i, {in_a, in_b});
        end
      end
    end
    cnt_a = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL ramp_sat t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      cnt_a += int'(en_a);
    end
    vectors++;
    if (cnt_a != 200) begin
      miscompares++; $display("FAIL pwm_200: en_a high %0d of 256, want 200", cnt_a);
    end
  endtask

  task automatic test_reverse();
    int settle_cnt, first01;
    settle_cnt = 0; first01 = 0;
    motorIn = 4'b0110;
    for (int i = 1; i <= 30; i++) begin
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL reverse t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      vectors++;
      if (in_b !== 2'b10 || settling[0] !== 1'b0) begin
        miscompares++; $display("FAIL reverse_b t=%0d: in_b %b settle_b %b want 10 0",
                                i, in_b, settling[0]);
      end
      settle_cnt += int'(settling[1]);
      if (in_a == 2'b01 && first01 == 0) first01 = i;
    end
    vectors++;
    if (settle_cnt != 16 || first01 != 19) begin
      miscompares++;
      $display("FAIL reverse_dead: settle %0d first01 %0d want 16 19", settle_cnt, first01);
    end
  endtask

  task automatic test_dead_restart();
    int settle_cnt, first10, seen01;
    settle_cnt = 0; first10 = 0; seen01 = 0;
    motorIn = 4'b1010;
    for (int i = 1; i <= 10; i++) begin
      if (i == 7) motorIn = 4'b0110;
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL restart_pre t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    motorIn = 4'b1010;
    for (int i = 1; i <= 24; i++) begin
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL restart t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (i <= 18) settle_cnt += int'(settling[1]);
      if (in_a == 2'b10 && first10 == 0) first10 = i;
      if (in_a == 2'b01) seen01++;
    end
    vectors++;
    if (settle_cnt != 18 || first10 != 19 || seen01 != 0) begin
      miscompares++;
      $display("FAIL restart_timing: settle %0d first10 %0d seen01 %0d want 18 19 0",
               settle_cnt, first10, seen01);
    end
  endtask

  task automatic test_brake();
    motorIn = 4'b0000;
    for (int i = 1; i <= 10; i++) begin
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL brake t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (i == 3) begin
        vectors++;
        if (dut_vec !== 8'b11111100) begin
          miscompares++; $display("FAIL brake_pins: got %b want 11111100", dut_vec);
        end
      end
    end
    motorIn = 4'b1001;
    for (int i = 1; i <= 24; i++) begin
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL brake_exit t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (i == 18 || i == 19) begin
        vectors++;
        if ({in_a, in_b, settling} !== ((i == 18) ? 6'b000011 : 6'b100100)) begin
          miscompares++;
          $display("FAIL brake_dead t=%0d: pins/settle %b", i, {in_a, in_b, settling});
        end
      end
    end
  endtask

  task automatic test_duty_drop();
    int cnt_a, cnt_b;
    cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 110; i++) begin
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL drop_pre t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
    duty = 8'd50;
    for (int i = 1; i <= PERIOD; i++) begin
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL drop t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      cnt_a += int'(en_a);
      cnt_b += int'(en_b);
    end
    vectors++;
    if (cnt_a != 50 || cnt_b != 50) begin
      miscompares++; $display("FAIL pwm_50: en_a %0d en_b %0d want 50 50", cnt_a, cnt_b);
    end
    motorEn = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL disable t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
      vectors++;
      if (in_b !== 2'b01 || (i == 2 && in_a !== 2'b10) ||
          (i == 3 && {in_a, en_a} !== 3'b000)) begin
        miscompares++;
        $display("FAIL disable_a t=%0d: in_a %b en_a %b in_b %b", i, in_a, en_a, in_b);
      end
    end
  endtask

  task automatic test_async_reset();
    motorEn = 2'b11;
    for (int pass = 0; pass < 2; pass++) begin
      // Pass 0: reset lands in DEAD; pass 1: reset lands mid-ramp.
      if (pass == 0) begin
        for (int i = 1; i <= 8; i++) begin
          if (i == 4) motorIn = 4'b0110;
          tick(); vectors++;
          if (dut_vec !== exp_vec()) begin
            miscompares++; $display("FAIL pre_rst t=%0d: got %b want %b", i, dut_vec, exp_vec());
          end
        end
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1 vectors++;
      if (dut_vec !== 8'h00) begin
        miscompares++; $display("FAIL async_rst pass%0d: got %b want 00000000", pass, dut_vec);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 24; i++) begin
        tick(); vectors++;
        if (dut_vec !== exp_vec()) begin
          miscompares++; $display("FAIL post_rst t=%0d: got %b want %b", i, dut_vec, exp_vec());
        end
        vectors++;
        if (settling !== 2'b00 || (i == 3 && {in_a, in_b} !== 4'b0110)) begin
          miscompares++;
          $display("FAIL rst_no_dead t=%0d: pins %b settle %b", i, {in_a, in_b}, settling);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 1; i <= 3000; i++) begin
      if ($urandom_range(0, 19) == 0) motorIn = 4'($urandom);
      if ($urandom_range(0, 59) == 0) motorEn = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 299) == 0) duty = 8'($urandom);
      tick(); vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL random t=%0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_reverse();
    test_dead_restart();
    test_brake();
    test_duty_drop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
